fft_uart_streamer: RTL and testbench

Captures one complete FFT output frame into an internal buffer and waits for the MCU handshake. It then streams the frame out over a built-in 8N1 UART with a sync header. This is the parametrised successor to the FIFO-control plus uart_tx pair between FFT_Control and the tx pin. It adds configurable width, frame length, baud divisor, optional imaginary-part transmission, frame alignment on the FFT index, and error and drop accounting.

---
 rtl/fft_uart_streamer.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_fft_uart_streamer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_uart_streamer.sv
// fft_uart_streamer: captures one aligned FFT frame into a buffer, waits for
// the MCU request, then sends "A5 5A cnt" plus the frame over an 8N1 UART.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid, in_index   FFT sample strobe and bin index
//   in_re, in_im         sample real/imag parts (im used when SEND_IM=1)
//   rx_ready             async MCU request, rising edge starts the send
//   tx_ready             low while a captured frame waits for the MCU
//   tx                   UART line, idle high
//   busy                 high from capture start until the last stop bit
//   frame_cnt, drop_cnt  frames sent (wraps) / frames dropped (saturates)
//   frame_err            one-cycle pulse on an index discontinuity
module fft_uart_streamer #(
    parameter int DATA_W   = 32,
    parameter int N_POINTS = 1024,
    parameter int ADDR_W   = 10,
    parameter int CLK_DIV  = 868,
    parameter int SEND_IM  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [15:0]       in_index,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              rx_ready,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        drop_cnt,
    output logic              frame_err
);

    // One buffer entry holds a whole point: {re, im} or just re.
    localparam int WORD_W = DATA_W * (1 + SEND_IM);
    localparam int BPP    = WORD_W / 8;
    localparam int BC_W   = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int DIV_W  = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        SEEK,
        CAPTURE,
        WAIT_HOST,
        SEND_HDR,
        SEND_DATA
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rx_m_q, rx_s_q, rx_p_q;
    logic [1:0]        hidx_q, hidx_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] pcnt_q, pcnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              last_q, last_d;
    logic [WORD_W-1:0] pt_q, pt_d;
    logic [9:0]        sh_q, sh_d;
    logic [3:0]        bit_q, bit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              act_q, act_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic [7:0]        dcnt_q, dcnt_d;
    logic              ferr_q, ferr_d;

    logic [WORD_W-1:0] mem [N_POINTS];
    logic [WORD_W-1:0] rd_data_q;
    logic [WORD_W-1:0] wr_word;
    logic [ADDR_W-1:0] wa;
    logic              we;
    logic              ld;
    logic [7:0]        ld_byte;
    logic              uart_done;
    logic              uart_rdy;
    logic              rx_rise;
    logic              sop;

    assign uart_done = act_q && (div_q == DIV_W'(CLK_DIV - 1)) && (bit_q == 4'd9);
    // The UART can take a new byte when idle or on its final stop-bit cycle,
    // which keeps characters back-to-back.
    assign uart_rdy  = !act_q || uart_done;
    assign rx_rise   = rx_s_q && !rx_p_q;
    assign sop       = in_valid && (in_index == 16'd0);

    always_comb begin
        wr_word = '0;
        wr_word[WORD_W-1 -: DATA_W] = in_re;
        if (SEND_IM != 0) begin
            wr_word[DATA_W-1:0] = in_im;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hidx_d    = hidx_q;
        bcnt_d    = bcnt_q;
        pcnt_d    = pcnt_q;
        rd_addr_d = rd_addr_q;
        last_d    = last_q;
        pt_d      = pt_q;
        fcnt_d    = fcnt_q;
        dcnt_d    = dcnt_q;
        ferr_d    = 1'b0;
        we        = 1'b0;
        wa        = cnt_q[ADDR_W-1:0];
        ld        = 1'b0;
        ld_byte   = 8'h00;

        unique case (state_q)
            SEEK: begin
                if (sop) begin
                    we      = 1'b1;
                    wa      = '0;
                    cnt_d   = (ADDR_W+1)'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    if (in_index == 16'(cnt_q)) begin
                        we    = 1'b1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == (ADDR_W+1)'(N_POINTS - 1)) begin
                            state_d = WAIT_HOST;
                        end
                    end else begin
                        ferr_d = 1'b1;
                        // A fresh index 0 restarts capture without a SEEK cycle.
                        if (in_index == 16'd0) begin
                            we    = 1'b1;
                            wa    = '0;
                            cnt_d = (ADDR_W+1)'(1);
                        end else begin
                            state_d = SEEK;
                        end
                    end
                end
            end
            WAIT_HOST: begin
                if (rx_rise) begin
                    state_d   = SEND_HDR;
                    hidx_d    = 2'd0;
                    rd_addr_d = '0;
                    pcnt_d    = '0;
                    bcnt_d    = '0;
                    last_d    = 1'b0;
                end
            end
            SEND_HDR: begin
                if (uart_rdy) begin
                    ld     = 1'b1;
                    hidx_d = hidx_q + 2'd1;
                    if (hidx_q == 2'd0) begin
                        ld_byte = 8'hA5;
                    end else if (hidx_q == 2'd1) begin
                        ld_byte = 8'h5A;
                    end else begin
                        ld_byte = fcnt_q;
                        state_d = SEND_DATA;
                    end
                end
            end
            SEND_DATA: begin
                if (uart_rdy) begin
                    if (last_q) begin
                        state_d = SEEK;
                        fcnt_d  = fcnt_q + 8'd1;
                        last_d  = 1'b0;
                    end else begin
                        ld = 1'b1;
                        // First byte of a point comes straight from the read
                        // port; the next point is fetched while it is sent.
                        if (bcnt_q == '0) begin
                            ld_byte   = rd_data_q[WORD_W-1 -: 8];
                            pt_d      = rd_data_q << 8;
                            rd_addr_d = rd_addr_q + 1'b1;
                        end else begin
                            ld_byte = pt_q[WORD_W-1 -: 8];
                            pt_d    = pt_q << 8;
                        end
                        if (bcnt_q == BC_W'(BPP - 1)) begin
                            bcnt_d = '0;
                            pcnt_d = pcnt_q + 1'b1;
                            if (pcnt_q == ADDR_W'(N_POINTS - 1)) begin
                                last_d = 1'b1;
                            end
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = SEEK;
        endcase

        if ((state_q == WAIT_HOST || state_q == SEND_HDR ||
             state_q == SEND_DATA) && sop && dcnt_q != 8'hFF) begin
            dcnt_d = dcnt_q + 8'd1;
        end
    end

    always_comb begin
        sh_d  = sh_q;
        bit_d = bit_q;
        div_d = div_q;
        act_d = act_q;
        if (ld) begin
            sh_d  = {1'b1, ld_byte, 1'b0};
            bit_d = 4'd0;
            div_d = '0;
            act_d = 1'b1;
        end else if (act_q) begin
            if (div_q == DIV_W'(CLK_DIV - 1)) begin
                div_d = '0;
                if (bit_q == 4'd9) begin
                    act_d = 1'b0;
                end else begin
                    sh_d  = {1'b1, sh_q[9:1]};
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SEEK;
            cnt_q     <= '0;
            rx_m_q    <= 1'b0;
            rx_s_q    <= 1'b0;
            rx_p_q    <= 1'b0;
            hidx_q    <= '0;
            bcnt_q    <= '0;
            pcnt_q    <= '0;
            rd_addr_q <= '0;
            last_q    <= 1'b0;
            pt_q      <= '0;
            sh_q      <= '1;
            bit_q     <= '0;
            div_q     <= '0;
            act_q     <= 1'b0;
            fcnt_q    <= '0;
            dcnt_q    <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_m_q    <= rx_ready;
            rx_s_q    <= rx_m_q;
            rx_p_q    <= rx_s_q;
            hidx_q    <= hidx_d;
            bcnt_q    <= bcnt_d;
            pcnt_q    <= pcnt_d;
            rd_addr_q <= rd_addr_d;
            last_q    <= last_d;
            pt_q      <= pt_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            act_q     <= act_d;
            fcnt_q    <= fcnt_d;
            dcnt_q    <= dcnt_d;
            ferr_q    <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wr_word;
        end
        rd_data_q <= mem[rd_addr_q];
    end

    // tx is forced high by reset through act_q, even mid-character.
    assign tx        = act_q ? sh_q[0] : 1'b1;
    assign busy      = (state_q != SEEK);
    assign tx_ready  = (state_q != WAIT_HOST);
    assign frame_cnt = fcnt_q;
    assign drop_cnt  = dcnt_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_fft_uart_streamer.sv
// Bench for fft_uart_streamer: two instances (re-only and re+im) share the
// stimulus; their UART lines are decoded and compared with a frame model.
module tb_fft_uart_streamer;

    localparam int DW = 16;
    localparam int NP = 8;
    localparam int AW = 3;
    localparam int CD = 4;
    localparam int ACT0 = (3 + NP * (DW / 8)) * 10 * CD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] in_index = '0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic rx_ready = 1'b0;
    logic rdy0, tx0, busy0, fe0, rdy1, tx1, busy1, fe1;
    logic [7:0] fc0, dc0, fc1, dc1;

    always #5 clk = ~clk;

    fft_uart_streamer #(.DATA_W(DW), .N_POINTS(NP), .ADDR_W(AW),
                        .CLK_DIV(CD), .SEND_IM(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_index(in_index), .in_re(in_re), .in_im(in_im),
        .rx_ready(rx_ready), .tx_ready(rdy0), .tx(tx0), .busy(busy0),
        .frame_cnt(fc0), .drop_cnt(dc0), .frame_err(fe0));

    fft_uart_streamer #(.DATA_W(DW), .N_POINTS(NP), .ADDR_W(AW),
                        .CLK_DIV(CD), .SEND_IM(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_index(in_index), .in_re(in_re), .in_im(in_im),
        .rx_ready(rx_ready), .tx_ready(rdy1), .tx(tx1), .busy(busy1),
        .frame_cnt(fc1), .drop_cnt(dc1), .frame_err(fe1));

    int pass_n = 0;
    int total_n = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // UART decoders, frame_err and tx-activity monitors
    bit dec_on [2];
    int dec_t [2];
    logic [7:0] dec_sh [2];
    logic txv [2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int stop_err = 0;
    int err0 = 0;
    int err1 = 0;
    bit act_arm = 0;
    bit act_run = 0;
    int act0 = 0;

    always @(negedge clk) begin
        txv[0] = tx0;
        txv[1] = tx1;
        if (!rst_n) begin
            dec_on[0] = 0;
            dec_on[1] = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!dec_on[d]) begin
                    if (txv[d] == 1'b0) begin
                        dec_on[d] = 1;
                        dec_t[d] = 0;
                    end
                end else begin
                    dec_t[d]++;
                    if (dec_t[d] % CD == CD / 2) begin
                        if (dec_t[d] / CD >= 1 && dec_t[d] / CD <= 8)
                            dec_sh[d][dec_t[d] / CD - 1] = txv[d];
                        if (dec_t[d] / CD == 9) begin
                            if (txv[d] != 1'b1) stop_err++;
                            if (d == 0) q0.push_back(dec_sh[d]);
                            else q1.push_back(dec_sh[d]);
                            dec_on[d] = 0;
                        end
                    end
                end
            end
            if (fe0) err0++;
            if (fe1) err1++;
            if (act_arm && tx0 == 1'b0) act_run = 1;
            if (act_run && busy0) act0++;
        end
    end

    // Frame model: the captured frame is the first run of valid samples
    // whose indices read 0,1,...,NP-1 in order.
    logic [15:0] re_m [NP];
    logic [15:0] im_m [NP];
    int s_idx[$];
    logic [15:0] s_re[$];
    logic [15:0] s_im[$];
    int exp_fc = 0;

    function automatic bit find_frame();
        bit ok;
        for (int p = 0; p + NP <= s_idx.size(); p++) begin
            ok = 1;
            for (int k = 0; k < NP; k++)
                if (s_idx[p + k] != k) ok = 0;
            if (ok) begin
                for (int k = 0; k < NP; k++) begin
                    re_m[k] = s_re[p + k];
                    im_m[k] = s_im[p + k];
                end
                return 1;
            end
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int idx, input logic [15:0] re,
                       input logic [15:0] im, input bit rec);
        in_valid = 1'b1;
        in_index = 16'(idx);
        in_re = re;
        in_im = im;
        if (rec) begin
            s_idx.push_back(idx);
            s_re.push_back(re);
            s_im.push_back(im);
        end
        tick();
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic put_frame(input bit pattern, input bit rec);
        for (int i = 0; i < NP; i++)
            put(i, pattern ? 16'(32'h1100 + i) : 16'($urandom),
                pattern ? 16'(32'h2200 + i) : 16'($urandom), rec);
    endtask

    task automatic clear_model();
        s_idx.delete();
        s_re.delete();
        s_im.delete();
    endtask

    task automatic send_and_check(input string nm, input bit drops);
        logic [7:0] e0[$];
        logic [7:0] e1[$];
        int bad;
        bit done;
        logic [7:0] d0s, d1s;
        e0 = '{8'hA5, 8'h5A, 8'(exp_fc)};
        e1 = '{8'hA5, 8'h5A, 8'(exp_fc)};
        for (int p = 0; p < NP; p++) begin
            e0.push_back(re_m[p][15:8]);
            e0.push_back(re_m[p][7:0]);
            e1.push_back(re_m[p][15:8]);
            e1.push_back(re_m[p][7:0]);
            e1.push_back(im_m[p][15:8]);
            e1.push_back(im_m[p][7:0]);
        end
        q0.delete();
        q1.delete();
        act0 = 0;
        act_run = 0;
        act_arm = 1;
        d0s = dc0;
        d1s = dc1;
        rx_ready = 1'b1;
        if (drops) begin
            done = 0;
            for (int n = 0; n < 400 && !done; n++) begin
                @(negedge clk);
                if (q0.size() >= 4) done = 1;
            end
            if (!done) chk({nm, "_data_timeout"}, 1, 0);
            #2;
            for (int f = 0; f < 3; f++) put_frame(0, 0);
        end
        done = 0;
        for (int n = 0; n < 4000 && !done; n++) begin
            @(negedge clk);
            if (!busy0 && !busy1) done = 1;
        end
        if (!done) chk({nm, "_busy_timeout"}, 1, 0);
        rx_ready = 1'b0;
        act_arm = 0;
        chk({nm, "_len0"}, q0.size(), e0.size());
        chk({nm, "_len1"}, q1.size(), e1.size());
        bad = 0;
        for (int i = 0; i < e0.size() && i < q0.size(); i++)
            if (q0[i] !== e0[i]) bad++;
        chk({nm, "_bytes0_bad"}, bad, 0);
        bad = 0;
        for (int i = 0; i < e1.size() && i < q1.size(); i++)
            if (q1[i] !== e1[i]) bad++;
        chk({nm, "_bytes1_bad"}, bad, 0);
        chk({nm, "_act_cycles"}, act0, ACT0);
        chk({nm, "_fcnt0"}, fc0, 8'(exp_fc + 1));
        chk({nm, "_fcnt1"}, fc1, 8'(exp_fc + 1));
        chk({nm, "_rdy0"}, rdy0, 1);
        if (drops) begin
            chk({nm, "_drop0"}, dc0, d0s + 8'd3);
            chk({nm, "_drop1"}, dc1, d1s + 8'd3);
        end
        exp_fc++;
    endtask

    typedef struct {
        string name;
        int len;
        int exp_err;
        bit exp_wait;
        bit pattern;
        bit drops;
    } vec_t;

    vec_t tab [5];
    int seqs [5][12];
    logic [31:0] w;
    bit found;
    bit done;
    int e0s, e1s;

    initial begin
        tab[0] = '{"full", 8, 0, 1, 1, 0};
        seqs[0] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0};
        tab[1] = '{"misalign", 11, 0, 1, 0, 0};
        seqs[1] = '{5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0};
        tab[2] = '{"skip3", 4, 1, 0, 0, 0};
        seqs[2] = '{0, 1, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[3] = '{"restart", 11, 1, 1, 0, 1};
        seqs[3] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7, 0};
        tab[4] = '{"noise", 12, 1, 1, 0, 0};
        seqs[4] = '{3, 0, 1, 5, 0, 1, 2, 3, 4, 5, 6, 7};

        repeat (2) @(negedge clk);
        chk("rst_tx0", tx0, 1);
        chk("rst_rdy0", rdy0, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_fe0", fe0, 0);
        chk("rst_cnts0", {fc0, dc0}, 0);
        chk("rst_tx1", tx1, 1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        for (int v = 0; v < 5; v++) begin
            clear_model();
            e0s = err0;
            e1s = err1;
            for (int k = 0; k < tab[v].len; k++)
                put(seqs[v][k],
                    tab[v].pattern ? 16'(32'h1100 + seqs[v][k]) : 16'($urandom),
                    tab[v].pattern ? 16'(32'h2200 + seqs[v][k]) : 16'($urandom), 1);
            repeat (3) tick();
            @(negedge clk);
            chk({tab[v].name, "_err0"}, err0 - e0s, tab[v].exp_err);
            chk({tab[v].name, "_err1"}, err1 - e1s, tab[v].exp_err);
            chk({tab[v].name, "_rdy0"}, rdy0, !tab[v].exp_wait);
            chk({tab[v].name, "_rdy1"}, rdy1, !tab[v].exp_wait);
            found = find_frame();
            if (tab[v].exp_wait) begin
                #2;
                send_and_check(tab[v].name, tab[v].drops);
                if (tab[v].pattern) begin
                    w = (q1.size() >= 19) ? {q1[15], q1[16], q1[17], q1[18]} : 32'h0;
                    chk("pt3_re_im", w, 32'h11032203);
                end
            end else begin
                chk({tab[v].name, "_seek_busy"}, busy0, 0);
            end
            repeat (2) tick();
        end

        // rx_ready already high when the frame completes: no send until a new edge
        clear_model();
        q0.delete();
        rx_ready = 1'b1;
        repeat (3) tick();
        put_frame(0, 1);
        found = find_frame();
        repeat (60) tick();
        @(negedge clk);
        chk("hs_hold_rdy", rdy0, 0);
        chk("hs_no_tx", q0.size(), 0);
        chk("hs_busy", busy0, 1);
        #2;
        rx_ready = 1'b0;
        repeat (4) tick();
        send_and_check("hs", 0);
        repeat (2) tick();

        // reset while a data bit is low on the line
        clear_model();
        put_frame(1, 1);
        found = find_frame();
        repeat (2) tick();
        q0.delete();
        rx_ready = 1'b1;
        done = 0;
        for (int n = 0; n < 800 && !done; n++) begin
            @(negedge clk);
            if (q0.size() >= 3 && dec_on[0] && dec_t[0] >= CD && tx0 == 1'b0)
                done = 1;
        end
        if (!done) chk("rst_mid_timeout", 1, 0);
        #1;
        rst_n = 1'b0;
        rx_ready = 1'b0;
        #1;
        chk("mid_rst_tx0", tx0, 1);
        chk("mid_rst_tx1", tx1, 1);
        chk("mid_rst_rdy0", rdy0, 1);
        chk("mid_rst_busy0", busy0, 0);
        chk("mid_rst_fcnt", fc0, 0);
        chk("mid_rst_drop", dc0, 0);
        exp_fc = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        clear_model();
        put(3, 16'($urandom), 16'($urandom), 1);
        put(4, 16'($urandom), 16'($urandom), 1);
        tick();
        @(negedge clk);
        chk("post_rst_seek", busy0, 0);
        #2;
        put_frame(0, 1);
        found = find_frame();
        repeat (2) tick();
        @(negedge clk);
        chk("post_rst_rdy0", rdy0, 0);
        #2;
        send_and_check("post_rst", 0);

        chk("stop_bits", stop_err, 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
